// File: rtl/pipeline_hazard_controller_pkg.sv
// Shared CPU definitions used by the hazard controller: FSM encoding and register constants.
package pipeline_hazard_controller_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StError   = 2'd2
  } hazard_state_e;

  localparam logic [4:0] RegX0 = 5'd0;

endpackage

// File: rtl/load_use_detector.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detector
  import pipeline_hazard_controller_pkg::*;
(
  input  logic [4:0] rs1_address,
  input  logic [4:0] rs2_address,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  logic [4:0] rd_address,
  input  logic       mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = uses_rs1 && (rs1_address == rd_address);
  assign rs2_hit  = uses_rs2 && (rs2_address == rd_address);
  // x0 is never really written, so a load targeting it creates no dependency.
  assign load_use = mem_read && (rd_address != RegX0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline stall/flush controller: load-use bubbles, branch squash, memory-wait freeze and timeout.
module pipeline_hazard_controller
  import pipeline_hazard_controller_pkg::*;
#(
  parameter int unsigned TIMEOUT   = 200,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [4:0]           id_rs1_address,
  input  logic [4:0]           id_rs2_address,
  input  logic                 id_uses_rs1,
  input  logic                 id_uses_rs2,
  input  logic [4:0]           ex_rd_address,
  input  logic                 ex_mem_read,
  input  logic                 ex_branch_taken,
  input  logic                 mem_ram_req,
  input  logic                 ram_ready,
  output logic                 pc_wren,
  output logic                 if_id_wren,
  output logic                 id_ex_wren,
  output logic                 ex_mem_wren,
  output logic                 mem_wb_wren,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 error,
  output logic [CNT_WIDTH-1:0] stall_count
);

  localparam int unsigned WaitWidth = $clog2(TIMEOUT + 1);
  localparam logic [WaitWidth-1:0] TimeoutVal = WaitWidth'(TIMEOUT);

  hazard_state_e        state_q, state_d;
  logic [WaitWidth-1:0] wait_q, wait_d;
  logic [CNT_WIDTH-1:0] stall_count_q;
  logic                 mem_stall;
  logic                 load_use;

  load_use_detector u_load_use_detector (
    .rs1_address (id_rs1_address),
    .rs2_address (id_rs2_address),
    .uses_rs1    (id_uses_rs1),
    .uses_rs2    (id_uses_rs2),
    .rd_address  (ex_rd_address),
    .mem_read    (ex_mem_read),
    .load_use    (load_use)
  );

  // A ready in the same cycle as the request is a zero-wait access.
  assign mem_stall = mem_ram_req && !ram_ready;

  always_comb begin
    pc_wren     = 1'b0;
    if_id_wren  = 1'b0;
    id_ex_wren  = 1'b0;
    ex_mem_wren = 1'b0;
    mem_wb_wren = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset || (state_q == StError) || mem_stall) begin
      // Frozen: the branch in EX stays put, so its flush lands once the pipeline advances.
    end else if (ex_branch_taken) begin
      pc_wren     = 1'b1;
      if_id_wren  = 1'b1;
      id_ex_wren  = 1'b1;
      ex_mem_wren = 1'b1;
      mem_wb_wren = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      id_ex_wren  = 1'b1;
      ex_mem_wren = 1'b1;
      mem_wb_wren = 1'b1;
      id_ex_flush = 1'b1;
    end else begin
      pc_wren     = 1'b1;
      if_id_wren  = 1'b1;
      id_ex_wren  = 1'b1;
      ex_mem_wren = 1'b1;
      mem_wb_wren = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          wait_d  = WaitWidth'(1);
          state_d = (wait_d >= TimeoutVal) ? StError : StMemWait;
        end
      end
      StMemWait: begin
        if (!mem_stall) begin
          wait_d  = '0;
          state_d = StRun;
        end else begin
          // wait_q < TIMEOUT here, so the increment cannot wrap.
          wait_d  = wait_q + WaitWidth'(1);
          state_d = (wait_d >= TimeoutVal) ? StError : StMemWait;
        end
      end
      StError: state_d = StError;
      default: begin
        state_d = StRun;
        wait_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StRun;
      wait_q        <= '0;
      stall_count_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (!pc_wren && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
        stall_count_q <= stall_count_q + CNT_WIDTH'(1);
      end
    end
  end

  assign error       = (state_q == StError);
  assign stall_count = stall_count_q;

endmodule
